// File: rtl/chan_arbiter.sv
// chan_arbiter: round-robin merger of per-channel block FIFOs into one 16-bit word stream.
// Optional header/data format checker is compiled in with CHAN_ARB_CHECK_EN.
module chan_arbiter #(
    parameter int NCH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH-1:0]    chan_req,
    input  logic [16*NCH-1:0] chan_data,
    output logic [NCH-1:0]    chan_ack,
    input  logic [NCH-1:0]    chan_en,
    input  logic              out_afull,
    output logic [15:0]       out_data,
    output logic              out_valid,
    output logic              out_last,
    output logic              busy,
    output logic              err
);
    localparam int GW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [2:0] {IDLE, HDR, LEN, BODY, DRAIN} state_t;

    state_t         state, state_nxt;
    logic [GW-1:0]  gnt, gnt_nxt, ptr, ptr_nxt;
    logic [8:0]     cnt, cnt_nxt;
    logic [1:0]     vld_pipe;
    logic           last_nxt, found;
    logic [15:0]    word;
    logic [NCH-1:0] cand;

    assign cand      = chan_req & chan_en;
    assign word      = chan_data[16*gnt +: 16];
    assign out_valid = vld_pipe[1];

    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        ptr_nxt   = ptr;
        cnt_nxt   = cnt;
        last_nxt  = 1'b0;
        found     = 1'b0;
        case (state)
            IDLE: begin
                if (|cand && !out_afull) begin
                    // ptr holds the index after the last grant, so the search starts there
                    for (int i = 0; i < NCH; i++) begin
                        if (!found && cand[(int'(ptr) + i) % NCH]) begin
                            found   = 1'b1;
                            gnt_nxt = GW'((int'(ptr) + i) % NCH);
                        end
                    end
                    ptr_nxt   = (int'(gnt_nxt) == NCH - 1) ? '0 : gnt_nxt + 1'b1;
                    state_nxt = HDR;
                end
            end
            HDR:  state_nxt = LEN;
            LEN: begin
                cnt_nxt = {8'd0, word[14]} + {1'b0, word[7:0]};
                if (cnt_nxt == 9'd0) begin
                    last_nxt  = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    state_nxt = BODY;
                end
            end
            BODY: begin
                cnt_nxt = cnt - 9'd1;
                if (cnt == 9'd1)
                    state_nxt = DRAIN;
            end
            DRAIN: begin
                last_nxt  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // vld_pipe[0]: a word was acked last cycle and is on chan_data now; [1]: it is on out_data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            gnt      <= '0;
            ptr      <= '0;
            cnt      <= '0;
            chan_ack <= '0;
            vld_pipe <= '0;
            out_data <= '0;
            out_last <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_nxt;
            gnt      <= gnt_nxt;
            ptr      <= ptr_nxt;
            cnt      <= cnt_nxt;
            chan_ack <= (state_nxt == HDR || state_nxt == BODY) ? (NCH'(1) << gnt_nxt) : '0;
            vld_pipe <= {vld_pipe[0], |chan_ack};
            busy     <= (state_nxt != IDLE);
            out_last <= vld_pipe[0] & last_nxt;
            if (vld_pipe[0])
                out_data <= word;
        end
    end

`ifdef CHAN_ARB_CHECK_EN
    logic trig_pend;

    // The first word after the header is a trigger word when the header has M set
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err       <= 1'b0;
            trig_pend <= 1'b0;
        end else if (vld_pipe[0]) begin
            if (state == LEN) begin
                if (!word[15])
                    err <= 1'b1;
                trig_pend <= word[14];
            end else if (trig_pend) begin
                if (!word[15])
                    err <= 1'b1;
                trig_pend <= 1'b0;
            end else if (word[15:12] != 4'd0) begin
                err <= 1'b1;
            end
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_chan_arbiter.sv
// Bench for chan_arbiter: table of single-block cases, hand sequences for arbitration corners,
// then randomized traffic checked cycle by cycle against a block-level reference model.
module tb_chan_arbiter;
    localparam int NCH  = 16;
    localparam int MAXC = 4096;

    logic              clk = 1'b0;
    logic              rst;
    logic [NCH-1:0]    chan_req, chan_ack, chan_en;
    logic [16*NCH-1:0] chan_data;
    logic              out_afull, out_valid, out_last, busy, err;
    logic [15:0]       out_data;

    chan_arbiter #(.NCH(NCH)) dut (
        .clk(clk), .rst(rst), .chan_req(chan_req), .chan_data(chan_data), .chan_ack(chan_ack),
        .chan_en(chan_en), .out_afull(out_afull), .out_data(out_data), .out_valid(out_valid),
        .out_last(out_last), .busy(busy), .err(err)
    );

    always #4 clk = ~clk;

    typedef struct {
        int          ch;
        logic [15:0] hdr, trig, dbase, dstep;
        int          exp_n, exp_acks, exp_busy;
        logic [15:0] exp_last;
    } vec_t;

    int checks = 0, failures = 0;
    int cyc = 0, rbase = 0, mdl_free = 0, mdl_last = 0;
    int ack_cnt = 0, busy_cnt = 0, multi_ack = 0;
    bit rnd_on = 1'b0;
    logic [NCH-1:0] ack_seen;
    logic [15:0]    fifo_q [NCH][$];
    logic [15:0]    mdl_q  [NCH][$];
    logic [15:0]    sent_q [$];
    logic [16:0]    got_q  [$];
    logic [NCH-1:0] exp_ack [MAXC];
    logic [18:0]    exp_out [MAXC];   // {busy, valid, last, data}

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, want);
        end
    endtask

    task automatic update_req();
        for (int i = 0; i < NCH; i++) chan_req[i] = (fifo_q[i].size() != 0);
    endtask

    task automatic push_block(input int ch, input logic [15:0] hdr, trig, dbase, dstep);
        logic [15:0] w [$];
        w.push_back(hdr);
        if (hdr[14]) w.push_back(trig);
        for (int k = 0; k < int'(hdr[7:0]); k++) w.push_back((dbase + 16'(k) * dstep) & 16'h0FFF);
        foreach (w[k]) begin
            fifo_q[ch].push_back(w[k]);
            sent_q.push_back(w[k]);
            if (rnd_on) mdl_q[ch].push_back(w[k]);
        end
        update_req();
    endtask

    // Reference: a granted block of N words acks at grant+1 and grant+3.., shows its header at
    // grant+3 and word w>0 at grant+4+w, and keeps the arbiter busy for 2 (N=1) or N+2 cycles.
    task automatic model_cycle();
        int rc = cyc - rbase;
        logic [NCH+18:0] act, want;
        act  = {chan_ack, busy, out_valid, out_valid & out_last, out_valid ? out_data : 16'h0};
        want = {exp_ack[rc], exp_out[rc]};
        check($sformatf("cycle%0d", rc), 64'(act), 64'(want));
        if (rc >= mdl_free && !out_afull) begin
            int g = -1;
            for (int k = 1; k <= NCH; k++) begin
                int c = (mdl_last + k) % NCH;
                if (g < 0 && chan_en[c] && mdl_q[c].size() != 0) g = c;
            end
            if (g >= 0) begin
                logic [15:0] hdr = mdl_q[g][0];
                int n = 1 + int'(hdr[14]) + int'(hdr[7:0]);
                int span = (n == 1) ? 2 : n + 2;
                exp_ack[rc+1][g] = 1'b1;
                for (int j = 0; j < n - 1; j++) exp_ack[rc+3+j][g] = 1'b1;
                for (int j = 1; j <= span; j++) exp_out[rc+j][18] = 1'b1;
                for (int w = 0; w < n; w++) begin
                    int t = (w == 0) ? rc + 3 : rc + 4 + w;
                    logic [15:0] wd = mdl_q[g].pop_front();
                    exp_out[t][17:0] = {1'b1, w == n - 1, wd};
                end
                mdl_free = rc + span + 1;
                mdl_last = g;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        ack_seen = chan_ack;
        if (|chan_ack) ack_cnt++;
        if ($countones(chan_ack) > 1) multi_ack++;
        if (busy) busy_cnt++;
        if (out_valid) got_q.push_back({out_last, out_data});
        if (rnd_on) model_cycle();
        @(posedge clk);
        #1;
        for (int i = 0; i < NCH; i++) begin
            if (ack_seen[i]) begin
                if (fifo_q[i].size() != 0) chan_data[16*i +: 16] = fifo_q[i].pop_front();
                else chan_data[16*i +: 16] = 16'hFFFF;
            end
        end
        update_req();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < NCH; i++) begin
            fifo_q[i].delete();
            mdl_q[i].delete();
        end
        ack_seen  = '0;
        chan_data = '0;
        out_afull = 1'b0;
        chan_en   = '1;
        update_req();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic clear_counts();
        got_q.delete();
        sent_q.delete();
        ack_cnt = 0; busy_cnt = 0; multi_ack = 0;
    endtask

    function automatic int stream_errs();
        int e = 0;
        if (got_q.size() != sent_q.size()) return 1000 + got_q.size();
        foreach (got_q[k]) if (got_q[k][15:0] !== sent_q[k]) e++;
        return e;
    endfunction

    function automatic int last_count();
        int e = 0;
        foreach (got_q[k]) if (got_q[k][16]) e++;
        return e;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t tbl [6];
        int   pend, e;
        logic [15:0] hdr;
        int   ch, l;
        tbl[0] = '{3,  16'h8304, 16'h0000, 16'h0001, 16'h0001, 5, 5, 7, 16'h0004};
        tbl[1] = '{0,  16'hC002, 16'h8ABC, 16'h0010, 16'h0010, 4, 4, 6, 16'h0020};
        tbl[2] = '{5,  16'h8500, 16'h0000, 16'h0000, 16'h0001, 1, 1, 2, 16'h8500};
        tbl[3] = '{15, 16'hCF00, 16'h8123, 16'h0000, 16'h0001, 2, 2, 4, 16'h8123};
        tbl[4] = '{7,  16'h8701, 16'h0000, 16'h0777, 16'h0001, 2, 2, 4, 16'h0777};
        tbl[5] = '{9,  16'hC905, 16'h9000, 16'h0100, 16'h0003, 7, 7, 9, 16'h010C};

        rst = 1'b1; chan_req = '0; chan_en = '1; out_afull = 1'b0; chan_data = '0;
        clear_counts();
        do_reset();
        check("reset_ack", 64'(chan_ack), 64'(0));
        check("reset_valid", 64'(out_valid), 64'(0));
        check("reset_last", 64'(out_last), 64'(0));
        check("reset_data", 64'(out_data), 64'(0));
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_err", 64'(err), 64'(0));

        foreach (tbl[v]) begin
            clear_counts();
            push_block(tbl[v].ch, tbl[v].hdr, tbl[v].trig, tbl[v].dbase, tbl[v].dstep);
            repeat (tbl[v].exp_n + 10) tick();
            check($sformatf("t%0d_words", v), 64'(got_q.size()), 64'(tbl[v].exp_n));
            check($sformatf("t%0d_acks", v), 64'(ack_cnt), 64'(tbl[v].exp_acks));
            check($sformatf("t%0d_busy", v), 64'(busy_cnt), 64'(tbl[v].exp_busy));
            check($sformatf("t%0d_order", v), 64'(stream_errs()), 64'(0));
            check($sformatf("t%0d_nlast", v), 64'(last_count()), 64'(1));
            check($sformatf("t%0d_lastword", v), 64'(got_q.size() != 0 ? got_q[$] : 17'h0),
                  64'({1'b1, tbl[v].exp_last}));
        end

        // Two requesters held steady: grants alternate and blocks stay contiguous
        do_reset(); clear_counts();
        push_block(0, 16'h8001, 16'h0, 16'h00A0, 16'h1);
        push_block(2, 16'h8201, 16'h0, 16'h00B0, 16'h1);
        push_block(0, 16'h8001, 16'h0, 16'h00A1, 16'h1);
        push_block(2, 16'h8201, 16'h0, 16'h00B1, 16'h1);
        repeat (30) tick();
        check("rr_order", 64'(stream_errs()), 64'(0));
        e = 0;
        foreach (got_q[k]) if (got_q[k][16] !== 1'(k % 2)) e++;
        check("rr_last", 64'(e), 64'(0));
        check("rr_onehot", 64'(multi_ack), 64'(0));

        // Disabled channel is never served
        do_reset(); clear_counts();
        chan_en = 16'h0004;
        push_block(0, 16'h8001, 16'h0, 16'h00C0, 16'h1);
        sent_q.delete();
        push_block(2, 16'h8201, 16'h0, 16'h00D0, 16'h1);
        repeat (20) tick();
        check("en_stream", 64'(stream_errs()), 64'(0));
        check("en_skip", 64'(fifo_q[0].size()), 64'(2));
        check("en_acks", 64'(ack_cnt), 64'(2));
        chan_en = '1;

        // Almost-full blocks a grant but not a block already started
        do_reset(); clear_counts();
        out_afull = 1'b1;
        push_block(4, 16'h8403, 16'h0, 16'h0050, 16'h1);
        repeat (10) tick();
        check("afull_noack", 64'(ack_cnt), 64'(0));
        check("afull_idle", 64'(busy_cnt), 64'(0));
        out_afull = 1'b0;
        tick();
        out_afull = 1'b1;
        repeat (15) tick();
        check("afull_stream", 64'(stream_errs()), 64'(0));
        check("afull_acks", 64'(ack_cnt), 64'(4));
        out_afull = 1'b0;

        // Reset in the middle of a block drops the ack at once
        do_reset(); clear_counts();
        push_block(6, 16'h8614, 16'h0, 16'h0010, 16'h1);
        repeat (5) tick();
        check("mid_ack", 64'(chan_ack), 64'(16'h0040));
        #1 rst = 1'b1;
        #1;
        check("async_ack", 64'(chan_ack), 64'(0));
        check("async_busy", 64'(busy), 64'(0));
        check("async_valid", 64'(out_valid), 64'(0));
        do_reset();

        // Malformed data word is forwarded unchanged; checker flags it
        clear_counts();
        fifo_q[1].push_back(16'h8103); fifo_q[1].push_back(16'h0001);
        fifo_q[1].push_back(16'h1FFF); fifo_q[1].push_back(16'h0003);
        sent_q.push_back(16'h8103); sent_q.push_back(16'h0001);
        sent_q.push_back(16'h1FFF); sent_q.push_back(16'h0003);
        update_req();
        repeat (14) tick();
        check("fmt_stream", 64'(stream_errs()), 64'(0));
`ifdef CHAN_ARB_CHECK_EN
        check("err_set", 64'(err), 64'(1));
        repeat (5) tick();
        check("err_sticky", 64'(err), 64'(1));
        do_reset();
        check("err_clear", 64'(err), 64'(0));
`else
        check("err_tied", 64'(err), 64'(0));
`endif

        // Randomized traffic against the reference model
        do_reset(); clear_counts();
        for (int c = 0; c < MAXC; c++) begin
            exp_ack[c] = '0;
            exp_out[c] = '0;
        end
        rnd_on = 1'b1; rbase = cyc + 1; mdl_free = 0; mdl_last = NCH - 1;
        for (int c = 0; c < 3300; c++) begin
            tick();
            if (c < 2500) begin
                pend = 0;
                for (int i = 0; i < NCH; i++) pend += mdl_q[i].size();
                if ($urandom_range(0, 5) == 0 && pend < 80) begin
                    ch  = int'($urandom_range(0, NCH - 1));
                    l   = ($urandom_range(0, 9) == 0) ? int'($urandom_range(8, 40)) : int'($urandom_range(0, 7));
                    hdr = {1'b1, 1'($urandom_range(0, 1)), 6'(ch), 8'(l)};
                    push_block(ch, hdr, 16'h8000 | 16'($urandom_range(0, 32767)),
                               16'($urandom_range(0, 4095)), 16'($urandom_range(1, 9)));
                end
                if (c % 16 == 0) chan_en = NCH'($urandom | $urandom);
                out_afull = ($urandom_range(0, 5) == 0);
            end else begin
                chan_en   = '1;
                out_afull = 1'b0;
            end
        end
        rnd_on = 1'b0;
        pend = 0;
        for (int i = 0; i < NCH; i++) pend += mdl_q[i].size() + fifo_q[i].size();
        check("rnd_drained", 64'(pend), 64'(0));
        check("rnd_onehot", 64'(multi_ack), 64'(0));
        check("rnd_err", 64'(err), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/chan_arbiter.md
# chan_arbiter

Round-robin arbiter that merges the per-channel block FIFOs of all channel processors into one 16-bit word stream. It sits directly downstream of the channel processors. It consumes their req/ack/dout read port one complete block at a time, so blocks from different channels never interleave, and it feeds the event-builder FIFO.

## Interface
Parameters:
- `NCH`, default 16: number of channel inputs (1..64).

Ports:
- `clk` in 1: 125 MHz system clock. One clock; all logic is on its rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `chan_req` in NCH: per-channel request. High means at least one complete block is committed in that channel's FIFO.
- `chan_data` in 16*NCH: per-channel registered FIFO output. Channel i occupies bits [16i+15:16i].
- `chan_ack` out NCH: per-channel read advance. One word is consumed per cycle high.
- `chan_en` in NCH: channel enable. Disabled channels are never granted.
- `out_afull` in 1: downstream almost-full. Downstream guarantees ≥260 free words while it is low.
- `out_data` out 16: merged word.
- `out_valid` out 1: `out_data` is valid this cycle. No backpressure exists inside a block.
- `out_last` out 1: marks the last word of a block, qualified by `out_valid`.
- `busy` out 1: high whenever the state is not IDLE.
- `err` out 1: sticky format error. Present only with the macro described under Configuration.

## Operation
Block format on the channel side:
- Header word: bit15=1, bit14=M, bits13:8 = channel number, bits7:0 = L.
- If M=1, a trigger word follows (bit15=1).
- Then L data words (bits15:12=0).
- Words per block: N = 1 + M + L. L=0 is legal.

Channel read-port rule:
- The word consumed by `chan_ack[i]` high in cycle t is sampled from `chan_data[i]` in cycle t+1.
- `chan_ack` may be held high over consecutive cycles, one word per cycle.

State machine:
- IDLE:
  - Candidates are channels with `chan_req & chan_en`.
  - If any candidate exists and `out_afull`=0, grant g = first candidate after the last granted index, wrapping at NCH-1→0. After reset the search starts at channel 0. Go to HDR.
- HDR: `chan_ack[g]`=1 for exactly one cycle. Go to LEN.
- LEN:
  - No ack.
  - Sample the header from `chan_data[g]` and forward it to output.
  - Load cnt = M + L (9 bits).
  - If cnt=0, mark the header as last and go to IDLE. Otherwise go to BODY.
- BODY:
  - `chan_ack[g]`=1 every cycle; cnt decrements each cycle.
  - The word sampled each cycle is the one acked in the previous cycle.
  - When the cycle with cnt=1 is acked, go to DRAIN.
- DRAIN:
  - No ack.
  - Sample the final word and mark it last. Go to IDLE.

General rules:
- At most one bit of `chan_ack` is high at any time. `chan_ack` is only ever high toward the granted channel.
- `chan_req`, `chan_en` and `out_afull` are ignored outside IDLE. Once a block is started it always completes.
- Within a block, `out_valid` is continuous except for the single bubble at LEN.

## Timing
- All outputs are registered. `out_data` and `out_last` are always registered copies of the sampled word.
- Latency: `chan_ack` in cycle t → word on `out_data` with `out_valid` in cycle t+2.
- Minimum block cost: N+3 cycles, i.e. IDLE, HDR, LEN, N-1 BODY cycles, DRAIN. For L=0, M=0: HDR, LEN, IDLE.
- Back-to-back: a new grant can be made in the IDLE cycle immediately after DRAIN or LEN.
- Reset values:
  - `chan_ack`=0, `out_valid`=0, `out_last`=0, `out_data`=0, `busy`=0, `err`=0.
  - State IDLE, round-robin pointer 0.
- `rst` asserted mid-block:
  - `chan_ack` drops immediately, asynchronously.
  - The partially read channel FIFO is not restored. System reset must also restart the channel processors.

## Configuration
- `CHAN_ARB_CHECK_EN` defined: the format checker is compiled in.
  - The word sampled at LEN must have bit15=1.
  - If M=1, the first BODY word must have bit15=1.
  - Every data word must have bits15:12=0.
  - Any violation sets `err` sticky until `rst`. The stream is still forwarded unchanged.
- Not defined: the checker logic is absent and `err` is tied to 0.

## Test plan
- Channel 3 only, self-trigger block with L=4 (header 0x8304, data 0x0001..0x0004):
  - 5 words out, in order.
  - `out_last` on 0x0004.
  - `chan_ack[3]` high for 5 cycles total: 1 in HDR, 4 in BODY.
- Channel 0 master block with L=2 (header 0xC002, trigger 0x8ABC, data 0x0010, 0x0020):
  - Output is 0xC002, 0x8ABC, 0x0010, 0x0020, with last on 0x0020.
  - Exactly 4 acks.
- `chan_req`=0x0005 held constant, L=1 blocks:
  - Grants alternate 0,2,0,2.
  - Blocks never interleave.
  - `chan_en`=0x0004 → only channel 2 is served.
- `out_afull`=1 with a request pending:
  - Stays in IDLE with no ack.
  - `out_afull` rising mid-block does not stop the block.
- Header L=0, M=0:
  - Single word out with `out_last`=1.
  - Returns to IDLE 2 cycles after grant.
- With `CHAN_ARB_CHECK_EN`, a data word 0x1FFF inside a block:
  - `err`=1 and stays high.
  - `rst` clears it. Without the macro, `err` stays 0.
